// File: rtl/line_track_ctrl_if.sv
// Purpose : sensor-in / mixer-code-out bundle of the line tracking controller.
// Latency : none, wires only.
// Backpressure: none; the mode code is a level consumed every cycle by the mixer.
// Signals : sensor[2:0] raw IR {left, mid, right}, 1 = over black line
//           mode[3:0]   mixer mode code
//           lost        line currently lost, controller steering on last direction
//           halt        prolonged loss, gates the PWM stage
// Modports: master drives sensor and observes the outputs; slave is the controller.
interface line_track_ctrl_if;
  logic [2:0] sensor;
  logic [3:0] mode;
  logic       lost;
  logic       halt;

  modport master (output sensor, input mode, input lost, input halt);
  modport slave  (input sensor, output mode, output lost, output halt);
endinterface

// File: rtl/line_track_ctrl.sv
// Purpose : converts three raw IR line sensors into the 4-bit mode code of the motor mixer.
// Latency : a steady sensor change reaches mode 2 + DEBOUNCE_CYCLES + 1 clk later.
// Backpressure: none; outputs are registered levels refreshed every cycle.
// Ports   : clk, rst_n (async active-low); bus (line_track_ctrl_if.slave):
//           sensor in, mode/lost/halt out.
// Config  : define LOST_TIMEOUT_EN to enable the HALT state, the loss timer and the
//           halt output; otherwise halt is tied 0 and loss lasts until the line returns.
module line_track_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LOST_TIMEOUT    = 200_000_000,
  parameter int CNT_W           = 32
) (
  input logic              clk,
  input logic              rst_n,
  line_track_ctrl_if.slave bus
);

  typedef enum logic [1:0] {TRACK, LOST_L, LOST_R, HALT} state_t;
  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  if (DEBOUNCE_CYCLES < 1 || LOST_TIMEOUT < 1) begin : g_bad_param
    $error("line_track_ctrl: DEBOUNCE_CYCLES and LOST_TIMEOUT must be >= 1");
  end

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input path: 2-FF synchroniser followed by the debouncer
  // ---------------------------------------------------------------------------
  logic [2:0]       sync_meta;
  logic [2:0]       sync;
  logic [2:0]       cand;
  logic [2:0]       stable;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == DB_MAX) ? cnt : cnt + CNT_ONE;

  // stable is loaded on the same edge the counter reaches DB_MAX, so a pattern
  // must be seen DEBOUNCE_CYCLES times in a row (load cycle included) to pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 3'b010;
      sync      <= 3'b010;
      cand      <= 3'b010;
      stable    <= 3'b010;
      cnt       <= '0;
    end else begin
      sync_meta <= bus.sensor;
      sync      <= sync_meta;
      if (sync != cand) begin
        cand <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt_nxt;
        if (cnt_nxt == DB_MAX) begin
          stable <= cand;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_d;
  dir_t       last_dir;
  dir_t       last_dir_d;
  logic [3:0] mode_q;
  logic [3:0] mode_d;
  logic       lost_q;
  logic       lost_d;
`ifdef LOST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(LOST_TIMEOUT - 1);
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tcnt_d;
  logic             halt_q;
  logic             halt_d;
`endif

  always_comb begin
    state_d    = state;
    last_dir_d = last_dir;
    mode_d     = mode_q;
    lost_d     = lost_q;
`ifdef LOST_TIMEOUT_EN
    tcnt_d     = tcnt;
    halt_d     = halt_q;
`endif
    if (stable != 3'b000) begin
      // Line visible: every state returns to TRACK. This branch is checked
      // first so a regained line beats a timeout expiring on the same cycle.
      state_d = TRACK;
      lost_d  = 1'b0;
`ifdef LOST_TIMEOUT_EN
      halt_d  = 1'b0;
`endif
      case (stable)
        3'b011, 3'b001: begin
          mode_d     = {1'b0, stable};
          last_dir_d = DIR_RIGHT;
        end
        3'b110, 3'b100: begin
          mode_d     = {1'b0, stable};
          last_dir_d = DIR_LEFT;
        end
        3'b010, 3'b111: begin
          mode_d = {1'b0, stable};
        end
        default: begin
          // 101 is a fork or a bad reading: keep the current code and direction.
        end
      endcase
    end else begin
      case (state)
        TRACK: begin
          lost_d = 1'b1;
`ifdef LOST_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (last_dir == DIR_RIGHT) begin
            state_d = LOST_R;
            mode_d  = 4'b1001;
          end else begin
            state_d = LOST_L;
            mode_d  = 4'b1000;
          end
        end
        LOST_L, LOST_R: begin
`ifdef LOST_TIMEOUT_EN
          if (tcnt == TO_MAX) begin
            state_d = HALT;
            halt_d  = 1'b1;
            lost_d  = 1'b0;
          end else begin
            tcnt_d = tcnt + CNT_ONE;
          end
`endif
        end
        default: begin
          // HALT with no line: hold; mode keeps its STAY code.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TRACK;
      last_dir <= DIR_LEFT;
      mode_q   <= 4'b0010;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_d;
      last_dir <= last_dir_d;
      mode_q   <= mode_d;
      lost_q   <= lost_d;
    end
  end

`ifdef LOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt   <= '0;
      halt_q <= 1'b0;
    end else begin
      tcnt   <= tcnt_d;
      halt_q <= halt_d;
    end
  end

  assign bus.halt = halt_q;
`else
  assign bus.halt = 1'b0;
`endif

  assign bus.mode = mode_q;
  assign bus.lost = lost_q;

endmodule

// File: tb/tb_line_track_ctrl.sv
// Purpose : directed self-checking bench for line_track_ctrl (DEBOUNCE_CYCLES=4, LOST_TIMEOUT=16).
// Latency : expectations count posedges from a sensor change made on a negedge.
// Backpressure: n/a; outputs are sampled on the negedge.
module tb_line_track_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  line_track_ctrl_if bus();

  line_track_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LOST_TIMEOUT   (16),
    .CNT_W          (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_lost;
    logic exp_halt;
    logic [3:0] exp_mode;
    checks = 0;
    errors = 0;

    // Reset state
    rst_n      = 1'b0;
    bus.sensor = 3'b010;
    step(3);
    chk4("rst_mode", bus.mode, 4'b0010);
    chk1("rst_lost", bus.lost, 1'b0);
    chk1("rst_halt", bus.halt, 1'b0);
    rst_n = 1'b1;
    step(10);
    chk4("idle_mode", bus.mode, 4'b0010);

    // 1. Latency: 2 sync + 4 debounce + 1 output = 7 clks
    bus.sensor = 3'b011;
    step(6);
    chk4("lat_6clk", bus.mode, 4'b0010);
    step(1);
    chk4("lat_7clk", bus.mode, 4'b0011);

    // 2. Three-cycle glitch is rejected
    step(5);
    bus.sensor = 3'b110;
    step(3);
    bus.sensor = 3'b011;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk4("glitch_hold", bus.mode, 4'b0011);
    end

    // 3. Lost right / lost left
    bus.sensor = 3'b001;
    step(10);
    chk4("steer_r", bus.mode, 4'b0001);
    bus.sensor = 3'b000;
    step(10);
    chk4("stay_r_mode", bus.mode, 4'b1001);
    chk1("stay_r_lost", bus.lost, 1'b1);
    bus.sensor = 3'b100;
    step(10);
    chk4("steer_l", bus.mode, 4'b0100);
    chk1("steer_l_lost", bus.lost, 1'b0);
    bus.sensor = 3'b000;
    step(10);
    chk4("stay_l_mode", bus.mode, 4'b1000);
    chk1("stay_l_lost", bus.lost, 1'b1);

    // 4. Timeout: LOST_L entered at posedge 7, HALT at posedge 23
    step(12);
    chk1("pre_halt_halt", bus.halt, 1'b0);
    chk1("pre_halt_lost", bus.lost, 1'b1);
    step(1);
`ifdef LOST_TIMEOUT_EN
    chk1("halt_halt", bus.halt, 1'b1);
    chk1("halt_lost", bus.lost, 1'b0);
`else
    chk1("halt_halt", bus.halt, 1'b0);
    chk1("halt_lost", bus.lost, 1'b1);
`endif
    chk4("halt_mode", bus.mode, 4'b1000);
    bus.sensor = 3'b010;
    step(6);
    chk4("unhalt_6clk", bus.mode, 4'b1000);
    step(1);
    chk4("unhalt_mode", bus.mode, 4'b0010);
    chk1("unhalt_halt", bus.halt, 1'b0);
    chk1("unhalt_lost", bus.lost, 1'b0);

    // Boundary: line regained on the exact timeout cycle (last_dir still LEFT)
    step(3);
    bus.sensor = 3'b000;
    step(7);
    chk4("bnd_enter_mode", bus.mode, 4'b1000);
    chk1("bnd_enter_lost", bus.lost, 1'b1);
    step(9);
    bus.sensor = 3'b011;
    step(6);
    chk4("bnd_pre_mode", bus.mode, 4'b1000);
    chk1("bnd_pre_halt", bus.halt, 1'b0);
    step(1);
    chk4("bnd_mode", bus.mode, 4'b0011);
    chk1("bnd_halt", bus.halt, 1'b0);
    chk1("bnd_lost", bus.lost, 1'b0);

    // Timer restarts from zero on a fresh LOST entry
    step(3);
    bus.sensor = 3'b000;
    step(7);
    chk4("tclr_mode", bus.mode, 4'b1001);
    step(15);
    chk1("tclr_pre_halt", bus.halt, 1'b0);
    chk1("tclr_pre_lost", bus.lost, 1'b1);
    step(1);
`ifdef LOST_TIMEOUT_EN
    chk1("tclr_halt", bus.halt, 1'b1);
`else
    chk1("tclr_halt", bus.halt, 1'b0);
`endif
    chk4("tclr_halt_mode", bus.mode, 4'b1001);

    // 5. Fork pattern holds mode and direction
    bus.sensor = 3'b110;
    step(10);
    chk4("left_mode", bus.mode, 4'b0110);
    bus.sensor = 3'b101;
    step(10);
    chk4("fork_mode", bus.mode, 4'b0110);
    chk1("fork_lost", bus.lost, 1'b0);
    bus.sensor = 3'b000;
    step(10);
    chk4("fork_dir_left", bus.mode, 4'b1000);

    // 6. Asynchronous reset in LOST_R
    bus.sensor = 3'b001;
    step(10);
    chk4("pre_arst_steer", bus.mode, 4'b0001);
    bus.sensor = 3'b000;
    step(10);
    chk4("pre_arst_mode", bus.mode, 4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("arst_mode", bus.mode, 4'b0010);
    chk1("arst_lost", bus.lost, 1'b0);
    chk1("arst_halt", bus.halt, 1'b0);
    step(3);
    chk4("arst_hold_mode", bus.mode, 4'b0010);
    rst_n = 1'b1;
    // 000 held after release: LOST_L at posedge 7 (sync restarted at 010)
    for (int k = 1; k <= 100; k++) begin
      step(1);
      exp_mode = (k < 7) ? 4'b0010 : 4'b1000;
`ifdef LOST_TIMEOUT_EN
      exp_lost = (k >= 7) && (k < 23);
      exp_halt = (k >= 23);
`else
      exp_lost = (k >= 7);
      exp_halt = 1'b0;
`endif
      chk4("hold_mode", bus.mode, exp_mode);
      chk1("hold_lost", bus.lost, exp_lost);
      chk1("hold_halt", bus.halt, exp_halt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
